// File: rtl/sr_latch_bank_ctrl.sv
// Sequencing controller and round-robin arbiter for a bank of gated SR latches.
// A granted request walks SETUP -> PULSE -> HOLD -> CHECK. The set and reset lines
// come from one captured op bit, so they can never both be high.
module sr_latch_bank_ctrl #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned PULSE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       req_op,
    input  logic [N_REQ*WIDTH-1:0] req_mask,
    input  logic [WIDTH-1:0]       q_in,
    output logic [N_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]       latch_set,
    output logic [WIDTH-1:0]       latch_reset,
    output logic                   latch_en,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {StIdle, StSetup, StPulse, StHold, StCheck} state_e;

    state_e             state_q, state_d;
    logic [PtrW-1:0]    ptr_q, ptr_d;
    logic [PtrW-1:0]    idx_q, idx_d;
    logic               op_q, op_d;
    logic [WIDTH-1:0]   mask_q, mask_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [WIDTH-1:0]   set_q, set_d;
    logic [WIDTH-1:0]   rst_q, rst_d;
    logic               en_q, en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [2*N_REQ-1:0] req_rot;
    logic               found;
    int                 sel_int;
    logic               sel_op;
    logic [WIDTH-1:0]   sel_mask;
    logic [N_REQ-1:0]   sel_onehot;
    logic               chk_err;
    logic [PtrW-1:0]    ptr_after;

    // Rotating-priority pick: first requester at or after ptr, wrapping.
    always_comb begin
        req_rot    = {req, req} >> ptr_q;
        found      = 1'b0;
        sel_int    = 0;
        sel_op     = 1'b0;
        sel_mask   = '0;
        sel_onehot = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            if (!found && req_rot[k]) begin
                found   = 1'b1;
                sel_int = int'(ptr_q) + k;
            end
        end
        if (sel_int >= int'(N_REQ)) begin
            sel_int = sel_int - int'(N_REQ);
        end
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (i == sel_int) begin
                sel_op        = req_op[i];
                sel_mask      = req_mask[i*WIDTH +: WIDTH];
                sel_onehot[i] = 1'b1;
            end
        end
    end

    assign chk_err   = ((q_in & mask_q) != (op_q ? mask_q : '0));
    assign ptr_after = (idx_q == PtrW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;

    // Next-state and registered-output decode.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        op_d    = op_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        set_d   = set_q;
        rst_d   = rst_q;
        en_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            // CHECK behaves like IDLE for arbitration so a pending request is
            // granted on the same edge that ends the transaction.
            StIdle, StCheck: begin
                state_d = StIdle;
                gnt_d   = '0;
                set_d   = '0;
                rst_d   = '0;
                if (found) begin
                    state_d = StSetup;
                    idx_d   = PtrW'(sel_int);
                    op_d    = sel_op;
                    mask_d  = sel_mask;
                    gnt_d   = sel_onehot;
                    set_d   = sel_op ? sel_mask : '0;
                    rst_d   = sel_op ? '0 : sel_mask;
                end
            end
            StSetup: begin
                if (mask_q == '0) begin
                    state_d = StCheck;
                    set_d   = '0;
                    rst_d   = '0;
                    done_d  = 1'b1;
                    err_d   = chk_err;
                    ptr_d   = ptr_after;
                end else begin
                    state_d = StPulse;
                    en_d    = 1'b1;
                    cnt_d   = 4'd1;
                end
            end
            StPulse: begin
                if (cnt_q == 4'(PULSE_CYCLES)) begin
                    state_d = StHold;
                end else begin
                    en_d  = 1'b1;
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StHold: begin
                state_d = StCheck;
                set_d   = '0;
                rst_d   = '0;
                done_d  = 1'b1;
                err_d   = chk_err;
                ptr_d   = ptr_after;
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    // State and output registers; reset clears everything, latch_en drops at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            idx_q   <= '0;
            op_q    <= 1'b0;
            mask_q  <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            set_q   <= '0;
            rst_q   <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            set_q   <= set_d;
            rst_q   <= rst_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign gnt         = gnt_q;
    assign latch_set   = set_q;
    assign latch_reset = rst_q;
    assign latch_en    = en_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule
